// File: rtl/spi_mstr_pkg.sv
// spi_pkg: shared types and constants for the scope front-end SPI master.
//   state_t      - transfer FSM states
//   SS_*         - slave select indices (trigger DAC, AFE gain DACs, EEPROM)
//   BIT_COUNT    - bits per transfer
//   BACK_PORCH_CLKS - clk cycles SS_n stays low after the last SCLK fall
//   ss_decode()  - slave index to one-hot-low SS_n pattern
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        BACK_PORCH = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [2:0] SS_TRIG = 3'd0;
    localparam logic [2:0] SS_CH1  = 3'd1;
    localparam logic [2:0] SS_CH2  = 3'd2;
    localparam logic [2:0] SS_CH3  = 3'd3;
    localparam logic [2:0] SS_EEP  = 3'd4;

    localparam int BIT_COUNT       = 16;
    localparam int BACK_PORCH_CLKS = 16;

    // Indices 5..7 have no device: nothing is selected, but the caller
    // still runs the transfer so command decode always sees a done pulse.
    function automatic logic [4:0] ss_decode(input logic [2:0] idx);
        logic [4:0] sel_n;
        sel_n = 5'h1F;
        case (idx)
            SS_TRIG: sel_n = 5'b11110;
            SS_CH1:  sel_n = 5'b11101;
            SS_CH2:  sel_n = 5'b11011;
            SS_CH3:  sel_n = 5'b10111;
            SS_EEP:  sel_n = 5'b01111;
            default: sel_n = 5'h1F;
        endcase
        return sel_n;
    endfunction

endpackage

// File: rtl/spi_mstr_sync2.sv
// sync2: two-flop synchronizer for the asynchronous MISO line.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (flops clear to 0)
//   d_i   - asynchronous input
//   q_o   - input synchronized to clk, two cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_mstr.sv
// spi_mstr: mode-0 (CPOL=0, CPHA=0) SPI master, 16-bit words, 5 slave selects.
//   clk, rst_n  - system clock, asynchronous active-low reset
//   wrt_SPI     - start strobe, accepted only in IDLE
//   SPI_data    - word to send MSB first, latched on acceptance
//   ss          - slave index, latched with SPI_data
//   MISO        - serial input (asynchronous, synchronized internally)
//   SCLK, MOSI  - serial clock and data out
//   SS_n        - active-low one-hot slave selects
//   SPI_done    - one-cycle completion pulse
//   rd_data     - low byte received in the last completed transfer
//   busy        - high from the accepting edge through the SPI_done cycle
//   state_dbg   - current FSM state, for observation only
//
// Handshake: wrt_SPI is a strobe, not a held request. It is taken on a clock
// edge where the FSM is IDLE; any strobe while busy (including the SPI_done
// cycle) is dropped, there is no queueing.
//
// All outputs are registered from the current state, so every output lags
// the internal state by one clock: the FSM enters SHIFT on the accepting
// edge and SS_n falls one edge later, SCLK rises 16 clk after that.
module spi_mstr
    import spi_pkg::*;
#(
    parameter int SCLK_DIV_LOG2 = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wrt_SPI,
    input  logic [15:0] SPI_data,
    input  logic [2:0] ss,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic [4:0] SS_n,
    output logic       SPI_done,
    output logic [7:0] rd_data,
    output logic       busy,
    output state_t     state_dbg
);

    localparam int DW = SCLK_DIV_LOG2;
    // Sample MISO one clk after the internal rising point (div MSB set).
    localparam logic [DW-1:0] DIV_CAPT = DW'((1 << (DW - 1)) + 1);
    localparam logic [DW-1:0] DIV_LAST = '1;
    localparam logic [DW-1:0] BP_LAST  = DW'(BACK_PORCH_CLKS - 1);
    localparam logic [4:0]    LAST_BIT = 5'(BIT_COUNT - 1);

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [4:0]    bit_cnt_q;
    logic [15:0]   shift_q;
    logic [2:0]    ss_q;
    logic          miso_bit_q;
    logic          sclk_q;
    logic          mosi_q;
    logic [4:0]    ss_n_q;
    logic          done_q;
    logic [7:0]    rd_q;
    logic          busy_q;
    logic          miso_s;
    logic [DW-1:0] div_d;

    sync2 u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (MISO),
        .q_o   (miso_s)
    );

    assign div_d = div_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ss_q       <= '0;
            miso_bit_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 5'h1F;
            done_q     <= 1'b0;
            rd_q       <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            sclk_q <= (state_q == SHIFT) ? div_q[DW-1] : 1'b0;
            mosi_q <= (state_q == SHIFT) ? shift_q[15] : 1'b0;
            ss_n_q <= (state_q == SHIFT || state_q == BACK_PORCH) ?
                      ss_decode(ss_q) : 5'h1F;
            done_q <= (state_q == DONE);
            // In IDLE busy follows the accepted strobe; elsewhere it holds
            // through DONE so the registered copy covers the SPI_done cycle.
            busy_q <= (state_q != IDLE) || wrt_SPI;

            case (state_q)
                IDLE: begin
                    if (wrt_SPI) begin
                        shift_q   <= SPI_data;
                        ss_q      <= ss;
                        div_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    div_q <= div_d;
                    if (div_q == DIV_CAPT) begin
                        miso_bit_q <= miso_s;
                    end
                    // div wrapping to 0 is the SCLK falling point.
                    if (div_q == DIV_LAST) begin
                        shift_q   <= {shift_q[14:0], miso_bit_q};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            div_q   <= '0;
                            state_q <= BACK_PORCH;
                        end
                    end
                end
                BACK_PORCH: begin
                    div_q <= div_d;
                    if (div_q == BP_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rd_q    <= shift_q[7:0];
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign SS_n      = ss_n_q;
    assign SPI_done  = done_q;
    assign rd_data   = rd_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_mstr.sv
module tb_spi_mstr;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  ss;
    logic [15:0] miso_word;
    logic [4:0]  exp_ssn;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int DONE_CYC = 529;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt_SPI = 1'b0;
  logic [15:0] SPI_data = '0;
  logic [2:0]  ss = '0;
  logic        MISO;
  logic        SCLK;
  logic        MOSI;
  logic [4:0]  SS_n;
  logic        SPI_done;
  logic [7:0]  rd_data;
  logic        busy;
  spi_pkg::state_t state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // slave model
  logic [15:0] sl_tx = '0;
  logic [15:0] sl_rx = '0;
  int rise_cnt = 0;

  spi_mstr dut (
    .clk(clk), .rst_n(rst_n), .wrt_SPI(wrt_SPI), .SPI_data(SPI_data),
    .ss(ss), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
    .SPI_done(SPI_done), .rd_data(rd_data), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  assign MISO = sl_tx[15];
  always @(posedge SCLK) begin
    sl_rx = {sl_rx[14:0], MOSI};
    rise_cnt = rise_cnt + 1;
  end
  always @(negedge SCLK) sl_tx = {sl_tx[14:0], 1'b0};

  function automatic logic [4:0] exp_sel(input logic [2:0] s);
    logic [4:0] one;
    one = 5'b00001;
    if (s > 3'd4) return 5'h1F;
    return ~(one << s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: call just after a negedge; the strobe is sampled at the next edge (edge 0)
  task automatic start(input vec_t v);
    SPI_data = v.data;
    ss = v.ss;
    sl_tx = v.miso_word;
    wrt_SPI = 1'b1;
    exp_q.push_back(v.exp_rd);
    @(posedge clk);
    #1 wrt_SPI = 1'b0;
  endtask

  // monitor one transfer from edge 1 until SPI_done (bounded)
  task automatic watch(input logic [4:0] exp_ssn, input bit reassert, output int done_cyc);
    bit ssn_ok;
    bit busy_ok;
    ssn_ok = 1'b1;
    busy_ok = 1'b1;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      wrt_SPI = reassert && (cyc == 99 || cyc == DONE_CYC - 1);
      if (wrt_SPI) SPI_data = 16'hFFFF;
      if (!busy) busy_ok = 1'b0;
      if (SPI_done) begin
        done_cyc = cyc;
        check("ssn_at_done", SS_n, 5'h1F);
        if (exp_q.size() == 0) check("sb_empty", 0, 1);
        else check("rd_data", rd_data, exp_q.pop_front());
        break;
      end
      if (SS_n !== exp_ssn) ssn_ok = 1'b0;
    end
    wrt_SPI = 1'b0;
    check("done_cycle", done_cyc, DONE_CYC);
    check("ssn_during", ssn_ok, 1);
    check("busy_during", busy_ok, 1);
  endtask

  task automatic idle_check(input int n);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || SS_n !== 5'h1F || SPI_done !== 1'b0 || SCLK !== 1'b0) ok = 1'b0;
    end
    check("idle_after", ok, 1);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int dc;
    bit ok;

    vecs[0] = '{16'h1380, 3'd0, 16'h0000, 5'h1E, 8'h00};
    vecs[1] = '{16'h0005, 3'd4, 16'hA5C3, 5'h0F, 8'hC3};
    vecs[2] = '{16'hBEEF, 3'd6, 16'h1234, 5'h1F, 8'h34};
    vecs[3] = '{16'h5AA5, 3'd2, 16'hFF81, 5'h1B, 8'h81};
    vecs[4] = '{16'h8001, 3'd1, 16'h7E18, 5'h1D, 8'h18};
    vecs[5] = '{16'h0000, 3'd7, 16'hFFFF, 5'h1F, 8'hFF};
    for (int i = 6; i < 8; i++) begin
      vecs[i].data = 16'($urandom_range(0, 65535));
      vecs[i].ss = 3'($urandom_range(0, 7));
      vecs[i].miso_word = 16'($urandom_range(0, 65535));
      vecs[i].exp_ssn = exp_sel(vecs[i].ss);
      vecs[i].exp_rd = vecs[i].miso_word[7:0];
    end

    // reset values
    #12;
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_ssn", SS_n, 5'h1F);
    check("rst_done", SPI_done, 0);
    check("rst_rd", rd_data, 8'h00);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven transfers
    for (int i = 0; i < 8; i++) begin
      rise_cnt = 0;
      start(vecs[i]);
      watch(vecs[i].exp_ssn, 1'b0, dc);
      check("slave_rx", sl_rx, vecs[i].data);
      check("sclk_rises", rise_cnt, 16);
      idle_check(3);
    end

    // strobes during a transfer and in the SPI_done cycle are dropped
    v = '{16'hC0DE, 3'd3, 16'h00A7, 5'h17, 8'hA7};
    rise_cnt = 0;
    start(v);
    watch(5'h17, 1'b1, dc);
    check("reassert_rx", sl_rx, 16'hC0DE);
    idle_check(40);
    check("reassert_rises", rise_cnt, 16);

    // asynchronous reset mid-transfer
    v = '{16'h3C3C, 3'd0, 16'h5500, 5'h1E, 8'h00};
    start(v);
    repeat (199) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ssn", SS_n, 5'h1F);
    check("abort_sclk", SCLK, 0);
    check("abort_busy", busy, 0);
    check("abort_rd", rd_data, 8'h00);
    exp_q.delete();
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (SPI_done !== 1'b0) ok = 1'b0;
    end
    check("abort_no_done", ok, 1);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{16'h9A5E, 3'd4, 16'h0066, 5'h0F, 8'h66};
    start(v);
    watch(5'h0F, 1'b0, dc);
    check("post_abort_rx", sl_rx, 16'h9A5E);
    idle_check(2);

    // back-to-back: second strobe sampled on the edge after SPI_done
    rise_cnt = 0;
    v = '{16'h1111, 3'd1, 16'h00F0, 5'h1D, 8'hF0};
    start(v);
    watch(5'h1D, 1'b0, dc);
    v = '{16'h2222, 3'd2, 16'h000F, 5'h1B, 8'h0F};
    start(v);
    check("b2b_gap_ssn", SS_n, 5'h1F);
    watch(5'h1B, 1'b0, dc);
    check("b2b_rx", sl_rx, 16'h2222);
    check("b2b_rises", rise_cnt, 32);
    idle_check(2);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mstr.md
# spi_mstr

SPI master for the scope's front end. Sits downstream of command decode: accepts a 16-bit word plus a 3-bit slave select and runs a mode-0 (CPOL=0, CPHA=0) transfer of that word to the selected device (trigger DAC, per-channel AFE gain DACs, calibration EEPROM). Returns the low received byte (EEPROM read data) and a one-cycle done pulse.

## Interface
- SCLK_DIV_LOG2, 5, log2 of SCLK period in clk cycles (32 clk per SCLK)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wrt_SPI  in  1  start strobe; sampled only in IDLE
- SPI_data  in  16  word to transmit, MSB first; latched on accepted wrt_SPI
- ss  in  3  slave index; latched with SPI_data
- MISO  in  1  serial input, asynchronous to clk
- SCLK  out  1  serial clock
- MOSI  out  1  serial output
- SS_n  out  5  active-low selects, one-hot-low, bit index = latched ss
- SPI_done  out  1  one-clk pulse, transfer complete
- rd_data  out  8  last 8 bits received
- busy  out  1  high from accepted wrt_SPI until SPI_done inclusive

## Operation
- States: IDLE, SHIFT, BACK_PORCH, DONE.
- IDLE: SCLK=0, SS_n=5'h1F. wrt_SPI=1 -> load shift_reg<=SPI_data, ss_q<=ss, div<=0, bit_cnt<=0, go SHIFT.
- SHIFT: div free-running, width SCLK_DIV_LOG2; SCLK = div[MSB]. SS_n[ss_q]=0 (ss_q 5..7: no select low, transfer still runs and completes). MOSI = shift_reg[15].
- Rising SCLK at div 15->16; first rise 16 clk after SS_n falls (front porch = half period).
- MISO passed through 2-flop synchronizer; captured into miso_bit when div==17.
- Falling SCLK at div 31->0: shift_reg <= {shift_reg[14:0], miso_bit}; bit_cnt++. On 16th fall -> BACK_PORCH, div<=0.
- BACK_PORCH: SCLK=0, SS_n still asserted for 16 clk, then DONE.
- DONE (1 clk): SS_n=5'h1F, SPI_done=1, rd_data<=shift_reg[7:0]; next IDLE.
- rd_data holds until next DONE. wrt_SPI outside IDLE ignored (no queueing).
- Width rules: bit_cnt 5 bits (0..16); div wraps modulo 32.

## Timing
- Reset values: SCLK=0, MOSI=0, SS_n=5'h1F, SPI_done=0, rd_data=8'h00, busy=0; state IDLE.
- wrt_SPI sampled at edge 0 -> SS_n low from edge 1; SCLK first high at edge 17; 16 SCLK periods (512 clk) -> BACK_PORCH at edge 513; SPI_done high edge 529 to 530; SS_n high edge 529.
- MOSI changes only on SCLK falling edges (and at start); stable across every rising edge.
- wrt_SPI in same cycle as SPI_done: ignored (state is DONE); accepted earliest the cycle after.
- rst_n low mid-transfer: all outputs to reset values immediately, no SPI_done; partial data discarded.
- Back-to-back: SS_n high for at least 1 clk between transfers.

## Structure
- Package spi_pkg: state typedef (IDLE, SHIFT, BACK_PORCH, DONE), SS index constants (SS_TRIG=0, SS_CH1..CH3 per AFE, SS_EEP=4), BIT_COUNT=16, BACK_PORCH_CLKS=16.
- One sub-module: sync2 (2-flop MISO synchronizer, reset to 0).

## Test plan
- SPI_data=16'h1380, ss=0, MISO=0 -> SS_n=5'h1E during transfer; slave model captures 16'h1380 on SCLK rises; SPI_done at cycle 529; rd_data=8'h00.
- EEPROM read: SPI_data=16'h0005, ss=4, slave returns 16'hxxC3 (MSB first, updated on falls) -> SS_n=5'h0F; rd_data=8'hC3 at SPI_done.
- ss=3'b110 -> SS_n stays 5'h1F whole transfer, SCLK toggles 16 times, SPI_done still pulses at 529.
- wrt_SPI re-asserted at cycles 100 and 529 -> both ignored, exactly one transfer; busy stays high to 529.
- rst_n pulled low at cycle 200 -> SS_n=5'h1F, SCLK=0, busy=0 same cycle; no SPI_done; next wrt_SPI runs full 529-cycle transfer.
- Two back-to-back transfers (second wrt_SPI at 530) -> SS_n high ≥1 clk between; SCLK exactly 32 rises total.
